// File: rtl/mu0_pkg.sv
// Shared MU0 controller definitions: state encoding, opcodes, ALU function codes,
// select encodings and the control-vector struct used by mu0_decode and mu0_control.
package mu0_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  localparam logic [1:0] FS_B   = 2'b00;
  localparam logic [1:0] FS_ADD = 2'b01;
  localparam logic [1:0] FS_SUB = 2'b10;
  localparam logic [1:0] FS_INC = 2'b11;

  localparam logic ADDR_PC   = 1'b0;
  localparam logic ADDR_IR   = 1'b1;
  localparam logic A_ACC     = 1'b0;
  localparam logic A_PC      = 1'b1;
  localparam logic B_MEM     = 1'b0;
  localparam logic B_IR      = 1'b1;
  localparam logic RNW_READ  = 1'b1;
  localparam logic RNW_WRITE = 1'b0;

  typedef struct packed {
    logic       ir_ce;
    logic       pc_ce;
    logic       acc_ce;
    logic       acc_oe;
    logic       addr_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] alu_fs;
    logic       mem_rq;
    logic       mem_rnw;
  } ctrl_t;

  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c           = '0;
    c.mem_rnw   = RNW_READ;
    c.alu_fs    = FS_B;
    return c;
  endfunction

endpackage

// File: rtl/mu0_decode.sv
// Combinational EXEC-phase decoder: opcode plus accumulator flags to control vector.
module mu0_decode
  import mu0_pkg::*;
(
  input  logic [3:0] ir_opcode,
  input  logic       acc_15,
  input  logic       accz,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = ctrl_idle();
    case (ir_opcode)
      OP_LDA: begin
        ctrl.addr_sel  = ADDR_IR;
        ctrl.mem_rq    = 1'b1;
        ctrl.mem_rnw   = RNW_READ;
        ctrl.alu_b_sel = B_MEM;
        ctrl.alu_fs    = FS_B;
        ctrl.acc_ce    = 1'b1;
      end
      OP_STO: begin
        ctrl.addr_sel  = ADDR_IR;
        ctrl.mem_rq    = 1'b1;
        ctrl.mem_rnw   = RNW_WRITE;
        ctrl.acc_oe    = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        ctrl.addr_sel  = ADDR_IR;
        ctrl.mem_rq    = 1'b1;
        ctrl.mem_rnw   = RNW_READ;
        ctrl.alu_a_sel = A_ACC;
        ctrl.alu_b_sel = B_MEM;
        ctrl.alu_fs    = (ir_opcode == OP_ADD) ? FS_ADD : FS_SUB;
        ctrl.acc_ce    = 1'b1;
      end
      OP_JMP, OP_JGE, OP_JNE: begin
        ctrl.alu_b_sel = B_IR;
        ctrl.alu_fs    = FS_B;
        if (ir_opcode == OP_JGE)      ctrl.pc_ce = ~acc_15;
        else if (ir_opcode == OP_JNE) ctrl.pc_ce = ~accz;
        else                          ctrl.pc_ce = 1'b1;
      end
      default: ctrl = ctrl_idle();
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer with retired-instruction counter.
// Define MU0_WAIT_EN to stall on mem_rq && !mem_rdy; otherwise mem_rdy is ignored.
module mu0_control
  import mu0_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ir_opcode,
  input  logic             acc_15,
  input  logic             accz,
  input  logic             mem_rdy,
  output logic             ir_ce,
  output logic             pc_ce,
  output logic             acc_ce,
  output logic             acc_oe,
  output logic             addr_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic [1:0]       alu_fs,
  output logic             mem_rq,
  output logic             mem_rnw,
  output logic             exec,
  output logic             halted,
  output logic [CNT_W-1:0] icount
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  ctrl_t            dec_ctrl;
  ctrl_t            ctrl;
  ctrl_t            out_ctrl;

  mu0_decode u_decode (
    .ir_opcode (ir_opcode),
    .acc_15    (acc_15),
    .accz      (accz),
    .ctrl      (dec_ctrl)
  );

`ifndef MU0_WAIT_EN
  logic unused_mem_rdy;
  assign unused_mem_rdy = mem_rdy;
`endif

  always_comb begin
    ctrl     = ctrl_idle();
    state_d  = state_q;
    icount_d = icount_q;
    case (state_q)
      ST_FETCH: begin
        ctrl.addr_sel  = ADDR_PC;
        ctrl.mem_rq    = 1'b1;
        ctrl.mem_rnw   = RNW_READ;
        ctrl.ir_ce     = 1'b1;
        ctrl.alu_a_sel = A_PC;
        ctrl.alu_fs    = FS_INC;
        ctrl.pc_ce     = 1'b1;
        state_d        = ST_EXEC;
      end
      ST_EXEC: begin
        ctrl     = dec_ctrl;
        state_d  = (ir_opcode == OP_STP) ? ST_HALT : ST_FETCH;
        icount_d = icount_q + CNT_W'(1);
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
`ifdef MU0_WAIT_EN
    // Stall keeps addresses/selects steady and only suppresses state and load enables.
    if (ctrl.mem_rq && !mem_rdy) begin
      state_d     = state_q;
      icount_d    = icount_q;
      ctrl.ir_ce  = 1'b0;
      ctrl.pc_ce  = 1'b0;
      ctrl.acc_ce = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      icount_q <= icount_d;
    end
  end

  // Reset gates outputs combinationally so no enable escapes in the reset cycle.
  always_comb begin
    out_ctrl = rst_n ? ctrl : ctrl_idle();
  end

  assign ir_ce     = out_ctrl.ir_ce;
  assign pc_ce     = out_ctrl.pc_ce;
  assign acc_ce    = out_ctrl.acc_ce;
  assign acc_oe    = out_ctrl.acc_oe;
  assign addr_sel  = out_ctrl.addr_sel;
  assign alu_a_sel = out_ctrl.alu_a_sel;
  assign alu_b_sel = out_ctrl.alu_b_sel;
  assign alu_fs    = out_ctrl.alu_fs;
  assign mem_rq    = out_ctrl.mem_rq;
  assign mem_rnw   = out_ctrl.mem_rnw;
  assign exec      = rst_n && (state_q == ST_EXEC);
  assign halted    = rst_n && (state_q == ST_HALT);
  assign icount    = icount_q;

endmodule

// File: tb/tb_mu0_control.sv
// Directed self-checking bench for mu0_control (CNT_W=4 to reach counter wrap).
module tb_mu0_control;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       ir_opcode;
  logic             acc_15, accz, mem_rdy;
  logic             ir_ce, pc_ce, acc_ce, acc_oe, addr_sel, alu_a_sel, alu_b_sel;
  logic [1:0]       alu_fs;
  logic             mem_rq, mem_rnw, exec, halted;
  logic [CNT_W-1:0] icount;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  always #5 clk = ~clk;

  mu0_control #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ir_opcode (ir_opcode),
    .acc_15    (acc_15),
    .accz      (accz),
    .mem_rdy   (mem_rdy),
    .ir_ce     (ir_ce),
    .pc_ce     (pc_ce),
    .acc_ce    (acc_ce),
    .acc_oe    (acc_oe),
    .addr_sel  (addr_sel),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .alu_fs    (alu_fs),
    .mem_rq    (mem_rq),
    .mem_rnw   (mem_rnw),
    .exec      (exec),
    .halted    (halted),
    .icount    (icount)
  );

  // Packed order: ir,pc,acc_ce,acc_oe,addr,a_sel,b_sel,fs[1:0],rq,rnw,exec,halted
  function automatic logic [12:0] v(input logic ir, pc, ac, oe, ad, a, b,
                                    input logic [1:0] fs,
                                    input logic rq, rnw, ex, h);
    return {ir, pc, ac, oe, ad, a, b, fs, rq, rnw, ex, h};
  endfunction

  logic [12:0] obs_v;
  assign obs_v = {ir_ce, pc_ce, acc_ce, acc_oe, addr_sel, alu_a_sel, alu_b_sel,
                  alu_fs, mem_rq, mem_rnw, exec, halted};

  logic [12:0] V_IDLE, V_FETCH, V_LDA, V_STO, V_ADD, V_SUB, V_JMP, V_JNT, V_EXNOP, V_HALT;
  logic [12:0] V_ADD_STALL;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH just after an edge; leaves the bench just after the EXEC edge.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic a15,
                           input logic z, input logic [12:0] exp_exec);
    ir_opcode = op;
    acc_15    = a15;
    accz      = z;
    #1;
    chk({tag, "_fetch"}, 32'(obs_v), 32'(V_FETCH));
    step();
    chk({tag, "_exec"}, 32'(obs_v), 32'(exp_exec));
    step();
  endtask

  initial begin
    V_IDLE      = v(0,0,0,0,0,0,0,2'b00,0,1,0,0);
    V_FETCH     = v(1,1,0,0,0,1,0,2'b11,1,1,0,0);
    V_LDA       = v(0,0,1,0,1,0,0,2'b00,1,1,1,0);
    V_STO       = v(0,0,0,1,1,0,0,2'b00,1,0,1,0);
    V_ADD       = v(0,0,1,0,1,0,0,2'b01,1,1,1,0);
    V_SUB       = v(0,0,1,0,1,0,0,2'b10,1,1,1,0);
    V_JMP       = v(0,1,0,0,0,0,1,2'b00,0,1,1,0);
    V_JNT       = v(0,0,0,0,0,0,1,2'b00,0,1,1,0);
    V_EXNOP     = v(0,0,0,0,0,0,0,2'b00,0,1,1,0);
    V_HALT      = v(0,0,0,0,0,0,0,2'b00,0,1,0,1);
    V_ADD_STALL = v(0,0,0,0,1,0,0,2'b01,1,1,1,0);

    rst_n = 1'b0; ir_opcode = 4'h0; acc_15 = 1'b0; accz = 1'b0; mem_rdy = 1'b1;
    step(); step();
    chk("reset_outputs", 32'(obs_v), 32'(V_IDLE));
    chk("reset_icount", 32'(icount), 32'd0);

    rst_n = 1'b1;
    run_instr("lda", 4'h0, 1'b0, 1'b0, V_LDA);
    chk("icount_lda", 32'(icount), 32'd1);
    run_instr("sto", 4'h1, 1'b0, 1'b0, V_STO);
    run_instr("add", 4'h2, 1'b0, 1'b0, V_ADD);
    run_instr("sub", 4'h3, 1'b0, 1'b0, V_SUB);
    run_instr("jmp", 4'h4, 1'b1, 1'b1, V_JMP);
    run_instr("jge_neg", 4'h5, 1'b1, 1'b0, V_JNT);
    run_instr("jge_pos", 4'h5, 1'b0, 1'b1, V_JMP);
    run_instr("jne_zero", 4'h6, 1'b0, 1'b1, V_JNT);
    run_instr("jne_nz", 4'h6, 1'b1, 1'b0, V_JMP);
    run_instr("nop_a", 4'hA, 1'b0, 1'b0, V_EXNOP);
    chk("icount_10", 32'(icount), 32'd10);
    chk("nop_back_fetch", 32'(obs_v), 32'(V_FETCH));

`ifdef MU0_WAIT_EN
    ir_opcode = 4'h2; #1;
    chk("stall_fetch", 32'(obs_v), 32'(V_FETCH));
    step();
    mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_add", 32'(obs_v), 32'(V_ADD_STALL));
      step();
    end
    mem_rdy = 1'b1; #1;
    chk("stall_release", 32'(obs_v), 32'(V_ADD));
    step();
    chk("stall_icount", 32'(icount), 32'd11);
    chk("stall_next_fetch", 32'(obs_v), 32'(V_FETCH));
    rst_n = 1'b0; #1; rst_n = 1'b1;
`endif

    run_instr("stp", 4'h7, 1'b0, 1'b0, V_EXNOP);
    for (int i = 0; i < 10; i++) begin
      chk("halt_outputs", 32'(obs_v), 32'(V_HALT));
      chk("halt_icount", 32'(icount), 32'(icount_expected_halt()));
      step();
    end

    rst_n = 1'b0; #1;
    chk("rst_pulse_outputs", 32'(obs_v), 32'(V_IDLE));
    chk("rst_pulse_icount", 32'(icount), 32'd0);
    rst_n = 1'b1; #1;
    chk("rst_pulse_fetch", 32'(obs_v), 32'(V_FETCH));

    step();
    ir_opcode = 4'h0; #1;
    chk("mid_exec_lda", 32'(obs_v), 32'(V_LDA));
    rst_n = 1'b0; #1;
    chk("mid_exec_abort", 32'(obs_v), 32'(V_IDLE));
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_instr("wrap_run", 4'hA, 1'b0, 1'b0, V_EXNOP);
    chk("icount_15", 32'(icount), 32'd15);
    run_instr("wrap_last", 4'hA, 1'b0, 1'b0, V_EXNOP);
    chk("icount_wrap", 32'(icount), 32'd0);
    chk("wrap_fetch", 32'(obs_v), 32'(V_FETCH));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // The optional stall segment retires one extra ADD before STP, then resets the counter.
  function automatic int unsigned icount_expected_halt();
`ifdef MU0_WAIT_EN
    return 1;
`else
    return 11;
`endif
  endfunction

endmodule

// File: doc/mu0_control.md
# mu0_control

Fetch/execute sequencer for the MU0 datapath. It consumes the accumulator status flags (`acc_15`, `accz`) and the IR opcode. It produces every register enable, including `acc_ce` and `acc_oe` for the accumulator, plus the mux selects, ALU function code and memory request. It also counts retired instructions and optionally stalls on a memory-ready handshake.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `ir_opcode` in 4: IR[15:12]; valid in EXEC.
- `acc_15` in 1: accumulator sign bit.
- `accz` in 1: accumulator-is-zero flag.
- `mem_rdy` in 1: memory transfer completes this cycle.
- `ir_ce`, `pc_ce`, `acc_ce` out 1: register load enables.
- `acc_oe` out 1: accumulator drives the data bus.
- `addr_sel` out 1: memory address source; 0 = PC, 1 = IR[11:0].
- `alu_a_sel` out 1: ALU A input; 0 = ACC, 1 = PC.
- `alu_b_sel` out 1: ALU B input; 0 = memory data, 1 = IR[11:0].
- `alu_fs` out 2: ALU function; 00 = B, 01 = A+B, 10 = A−B, 11 = A+1.
- `mem_rq` out 1: memory request.
- `mem_rnw` out 1: 1 = read, 0 = write.
- `exec` out 1: state is EXEC.
- `halted` out 1: state is HALT.
- `icount` out CNT_W: retired-instruction count.

## Operation
- States: FETCH, EXEC, HALT.
  - Reset state is FETCH.
  - FETCH → EXEC.
  - EXEC → FETCH, except opcode 7, which goes EXEC → HALT.
  - HALT is absorbing until `rst_n` is low.
- Idle defaults: every enable 0, `mem_rq` = 0, `mem_rnw` = 1, all selects 0, `alu_fs` = 00.
- FETCH:
  - `addr_sel`=0, `mem_rq`=1, `mem_rnw`=1, `ir_ce`=1.
  - `alu_a_sel`=1, `alu_fs`=11, `pc_ce`=1.
- EXEC, decoded from `ir_opcode`:
  - 0 LDA: `addr_sel`=1, read, `alu_b_sel`=0, `alu_fs`=00, `acc_ce`=1.
  - 1 STO: `addr_sel`=1, `mem_rq`=1, `mem_rnw`=0, `acc_oe`=1.
  - 2 ADD: `addr_sel`=1, read, `alu_a_sel`=0, `alu_b_sel`=0, `alu_fs`=01, `acc_ce`=1.
  - 3 SUB: as ADD, but `alu_fs`=10.
  - 4 JMP: `alu_b_sel`=1, `alu_fs`=00, `pc_ce`=1.
  - 5 JGE: as JMP, but `pc_ce` = ~`acc_15`.
  - 6 JNE: as JMP, but `pc_ce` = ~`accz`.
  - 7 STP: idle defaults.
  - 8–F: idle defaults (NOP).
- Flags are sampled combinationally during EXEC. The accumulator only changes on clock edges, so the flags reflect the previous instruction's result.
- `icount` increments on the edge that completes EXEC, STP and NOPs included. It wraps from all-ones to 0. It does not change in FETCH or HALT.

## Timing
- While `rst_n`=0:
  - state = FETCH, `icount` = 0.
  - Every output is forced to its idle default, with `exec`=0 and `halted`=0.
- Each instruction takes 2 cycles (FETCH + EXEC) when there are no stalls.
- Outputs are combinational from the state, `ir_opcode`, flags and `mem_rdy`; there is no output register.
- Reset asserted mid-EXEC or mid-stall aborts immediately. No enable pulse is issued in the reset cycle.

## Configuration
- `MU0_WAIT_EN` defined:
  - In any cycle with `mem_rq`=1 and `mem_rdy`=0, the state holds and `ir_ce`/`pc_ce`/`acc_ce` are forced 0.
  - `mem_rq`, `mem_rnw`, `addr_sel`, `acc_oe` and the ALU selects stay stable during the stall.
  - `icount` does not increment on a stalled EXEC.
- `MU0_WAIT_EN` undefined:
  - Memory is single-cycle; `mem_rdy` is ignored.
  - The port remains present.

## Structure
- Shared package `mu0_pkg`:
  - state enum.
  - opcode constants (LDA..STP).
  - `alu_fs` codes.
  - select encodings.
- Sub-module `mu0_decode`: purely combinational opcode → EXEC control vector. The sequencer owns state, stall gating and `icount`.

## Test plan
- Reset release, then LDA (opcode 0) from mem 0x0010=0x1234 → cycle 1 FETCH with `ir_ce`=`pc_ce`=1, `alu_fs`=11; cycle 2 `acc_ce`=1, `alu_fs`=00, `addr_sel`=1; `icount`=1.
- STO → `mem_rnw`=0, `acc_oe`=1, `acc_ce`=0 in EXEC.
- JGE with `acc_15`=1 → `pc_ce`=0; JGE with `acc_15`=0 → `pc_ce`=1. JNE with `accz`=1 → `pc_ce`=0.
- STP → `halted`=1 from the next cycle, outputs idle for 10 cycles, `icount` frozen; `rst_n` pulse → FETCH, `icount`=0.
- `MU0_WAIT_EN` on, `mem_rdy` low for 3 cycles during an ADD EXEC → no `acc_ce` for 3 cycles, `mem_rq` held, then `acc_ce`=1 on the `mem_rdy` cycle; `icount` +1 once.
- Preload `icount` near wrap (CNT_W=4, 15 instructions + 1) → `icount` reads 0; opcode 0xA → NOP, returns to FETCH.
